// File: rtl/ycbcr_skin_ctrl_if.sv
// ycbcr_skin_ctrl_if: pixel-in and mask-out valid/ready streams with frame markers.
interface ycbcr_skin_ctrl_if;
    logic       in_valid, in_ready, in_sof, in_eof;
    logic [7:0] in_y, in_cb, in_cr;
    logic       out_valid, out_ready, out_sof, out_eof;
    logic [7:0] out_mask;
    modport master (
        output in_valid, in_y, in_cb, in_cr, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, out_mask, out_sof, out_eof
    );
    modport slave (
        input  in_valid, in_y, in_cb, in_cr, in_sof, in_eof, out_ready,
        output in_ready, out_valid, out_mask, out_sof, out_eof
    );
endinterface

// File: rtl/ycbcr_skin_ctrl.sv
// ycbcr_skin_ctrl: frame sequencer for the YCbCr skin thresholder; shadow thresholds applied at
// start-of-frame, two-register pixel/mask pipeline and per-frame skin-pixel counting.
module ycbcr_skin_ctrl #(
    parameter int         CNT_W  = 20,
    parameter logic [7:0] TA_RST = 8'h80,
    parameter logic [7:0] TB_RST = 8'h8F,
    parameter logic [7:0] TC_RST = 8'h80,
    parameter logic [7:0] TD_RST = 8'h9F
) (
    input  logic             clk,
    input  logic             rst,
    ycbcr_skin_ctrl_if.slave bus,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    output logic [7:0]       thr_y,
    output logic [7:0]       thr_cb,
    output logic [7:0]       thr_cr,
    output logic [7:0]       thr_ta,
    output logic [7:0]       thr_tb,
    output logic [7:0]       thr_tc,
    output logic [7:0]       thr_td,
    input  logic [7:0]       thr_binary,
    output logic [CNT_W-1:0] skin_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             frame_done,
    output logic             frame_err
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;
    logic [7:0] sh_ta, sh_tb, sh_tc, sh_td;
    logic s1_valid, s1_sof, s1_eof;
    logic adv, acc, take, move, skin;
    logic [CNT_W-1:0] cnt_upd;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv;
    assign acc          = bus.in_valid && bus.in_ready;
    assign take         = acc && (bus.in_sof || state == ACTIVE);
    assign move         = s1_valid && adv;
    assign skin         = thr_binary != 8'd0;
    // all-ones count is the saturation point
    assign cnt_upd = s1_sof ? CNT_W'(skin)
                   : (&skin_count ? skin_count : skin_count + CNT_W'(skin));

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        if (take) state_nxt = bus.in_eof ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_ta <= TA_RST;
            sh_tb <= TB_RST;
            sh_tc <= TC_RST;
            sh_td <= TD_RST;
        end else begin
            sh_ta <= (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : sh_ta;
            sh_tb <= (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : sh_tb;
            sh_tc <= (cfg_we && cfg_addr == 2'd2) ? cfg_wdata : sh_tc;
            sh_td <= (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : sh_td;
        end
    end

    // sof latches the pre-write shadow: NBA reads sh_* before a same-edge cfg write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_ta <= TA_RST;
            thr_tb <= TB_RST;
            thr_tc <= TC_RST;
            thr_td <= TD_RST;
        end else if (take && bus.in_sof) begin
            thr_ta <= sh_ta;
            thr_tb <= sh_tb;
            thr_tc <= sh_tc;
            thr_td <= sh_td;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sof   <= 1'b0;
            s1_eof   <= 1'b0;
            thr_y    <= 8'd0;
            thr_cb   <= 8'd0;
            thr_cr   <= 8'd0;
        end else if (bus.in_ready) begin
            s1_valid <= take;
            if (take) begin
                s1_sof <= bus.in_sof;
                s1_eof <= bus.in_eof;
                thr_y  <= bus.in_y;
                thr_cb <= bus.in_cb;
                thr_cr <= bus.in_cr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_mask  <= 8'd0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_mask <= thr_binary;
                bus.out_sof  <= s1_sof;
                bus.out_eof  <= s1_eof;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skin_count  <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_done <= move && s1_eof;
            frame_err  <= take && bus.in_sof && state == ACTIVE;
            if (move) skin_count <= cnt_upd;
            if (move && s1_eof) frame_count <= cnt_upd;
        end
    end
endmodule
